// File: rtl/hub75_rx_if.sv
// Framebuffer write bus produced by the HUB75 panel emulator.
interface hub75_rx_if;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [2:0]  wr_data;
    logic        frame_start;
    logic        overrun;
    logic [15:0] on_cycles;

    modport master (
        output wr_en, wr_addr, wr_data,
        output frame_start, overrun, on_cycles
    );
    modport slave (
        input wr_en, wr_addr, wr_data,
        input frame_start, overrun, on_cycles
    );
endinterface

// File: rtl/hub75_rx.sv
// HUB75 receive side: emulates a 64-column 1/32-scan panel and streams
// each latched row pair into a framebuffer, one pixel per clk.
module hub75_rx #(
    parameter int WIDTH       = 64,
    parameter int ADDR_BITS   = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 latch,
    input  logic                 blank,
    input  logic [ADDR_BITS-1:0] addry,
    input  logic [2:0]           rgb0,
    input  logic [2:0]           rgb1,
    hub75_rx_if.master           fb
);
    localparam int SW = 3 + ADDR_BITS + 6;
    localparam int IW = $clog2(2 * WIDTH);
    localparam int XW = $clog2(WIDTH);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * WIDTH - 1);

    logic [SW-1:0]        r_sync [SYNC_STAGES];
    logic                 r_sclk_d;
    logic                 r_latch_d;
    logic [5:0]           r_shift [WIDTH];
    logic [5:0]           r_hold  [WIDTH];
    logic [15:0]          r_blank_cnt;
    logic [0:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic [ADDR_BITS-1:0] r_row;
    logic                 r_wr_en;
    logic [11:0]          r_wr_addr;
    logic [2:0]           r_wr_data;
    logic                 r_frame;
    logic                 r_overrun;
    logic [15:0]          r_on_cycles;

    wire [SW-1:0] w_pins = {sclk, latch, blank, addry, rgb1, rgb0};
    wire [SW-1:0] w_sy   = r_sync[SYNC_STAGES-1];

    wire                 w_sclk  = w_sy[SW-1];
    wire                 w_latch = w_sy[SW-2];
    wire                 w_blank = w_sy[SW-3];
    wire [ADDR_BITS-1:0] w_addr  = w_sy[6 +: ADDR_BITS];
    wire [5:0]           w_pix   = w_sy[5:0];

    wire w_sclk_rise  = w_sclk & ~r_sclk_d;
    wire w_latch_rise = w_latch & ~r_latch_d;

    wire          w_half = r_idx[IW-1];
    wire [XW-1:0] w_x    = r_idx[XW-1:0];
    wire [5:0]    w_ent  = r_hold[w_x];
    wire [2:0]    w_data = w_half ? w_ent[5:3] : w_ent[2:0];
    wire [11:0]   w_waddr = 12'({w_half, r_row, w_x});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_sclk_d  <= 1'b0;
            r_latch_d <= 1'b0;
        end else begin
            r_sync[0] <= w_pins;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_sclk_d  <= w_sclk;
            r_latch_d <= w_latch;
        end
    end

    // Newest pixel at x = 0, like a real panel's chained shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < WIDTH; j++) r_shift[j] <= '0;
        end else if (w_sclk_rise) begin
            r_shift[0] <= w_pix;
            for (int j = 1; j < WIDTH; j++) r_shift[j] <= r_shift[j-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank_cnt <= '0;
            r_on_cycles <= '0;
        end else if (w_latch_rise) begin
            r_on_cycles <= r_blank_cnt;
            r_blank_cnt <= '0;
        end else if (!w_blank && r_blank_cnt != 16'hFFFF) begin
            r_blank_cnt <= r_blank_cnt + 16'd1;
        end
    end

    // The hold copy isolates the outgoing stream from ongoing shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < WIDTH; j++) r_hold[j] <= '0;
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_row     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_frame   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_latch_rise) begin
            for (int j = 0; j < WIDTH; j++) r_hold[j] <= r_shift[j];
            r_overrun <= (r_state == S_STREAM);
            r_state   <= S_STREAM;
            r_idx     <= '0;
            r_row     <= w_addr;
            r_wr_en   <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_state == S_STREAM) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_waddr;
                r_wr_data <= w_data;
                r_frame   <= (r_idx == '0) && (r_row == '0);
                r_idx     <= r_idx + 1'b1;
                if (r_idx == LAST_IDX) begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                end
            end else begin
                r_wr_en <= 1'b0;
                r_frame <= 1'b0;
            end
        end
    end

    assign fb.wr_en       = r_wr_en;
    assign fb.wr_addr     = r_wr_addr;
    assign fb.wr_data     = r_wr_data;
    assign fb.frame_start = r_frame;
    assign fb.overrun     = r_overrun;
    assign fb.on_cycles   = r_on_cycles;
endmodule
